// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max pooling over a raster-ordered m x m stream, using a half-row line buffer.
// Optional fused ReLU on the pooled value when MAXPOOL_RELU_EN is defined.
module conv_maxpool #(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 12,
    parameter int unsigned m = 6
) (
    input  logic         clk,
    input  logic         global_rst_n,
    input  logic         ce,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    input  logic         end_in,
    output logic [N-1:0] data_out,
    output logic         valid_out,
    output logic         end_out
);

    localparam int unsigned CW = (m > 1) ? $clog2(m) : 1;
    localparam int unsigned H  = (m / 2 > 0) ? m / 2 : 1;
    localparam int unsigned LW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] PosLast = CW'(m - 1);
    localparam logic [CW-1:0] WinLast = CW'(2 * H - 1);

    if (m < 2 || m > 256 || Q >= N) begin : g_param_check
        $error("conv_maxpool: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StEvenRow, StOddRow} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  linebuf_q [H];
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          end_q, end_d;

    logic          accept;
    logic          odd_row;
    logic          odd_col;
    logic          lb_we;
    logic          emit;
    logic [LW-1:0] lb_idx;
    logic signed [N-1:0] pair_max;
    logic signed [N-1:0] pool_max;
    logic signed [N-1:0] result;

    assign accept  = ce & valid_in;
    assign odd_row = (state_q == StOddRow);
    assign odd_col = col_q[0];
    assign lb_idx  = LW'(col_q >> 1);

    always_comb begin
        pair_max = ($signed(hold_q) > $signed(data_in)) ? $signed(hold_q) : $signed(data_in);
        pool_max = ($signed(linebuf_q[lb_idx]) > pair_max) ? $signed(linebuf_q[lb_idx])
                                                             : pair_max;
`ifdef MAXPOOL_RELU_EN
        result = pool_max[N-1] ? '0 : pool_max;
`else
        result = pool_max;
`endif
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        lb_we   = 1'b0;
        emit    = 1'b0;
        if (accept) begin
            if (!odd_col) begin
                hold_d = data_in;
            end else if (odd_row) begin
                emit = 1'b1;
            end else begin
                lb_we = 1'b1;
            end

            if (end_in || (col_q == PosLast && row_q == PosLast)) begin
                col_d   = '0;
                row_d   = '0;
                state_d = StIdle;
            end else if (col_q == PosLast) begin
                col_d = '0;
                row_d = row_q + 1'b1;
                unique case (state_q)
                    StOddRow: state_d = StEvenRow;
                    default:  state_d = StOddRow;
                endcase
            end else begin
                col_d = col_q + 1'b1;
                unique case (state_q)
                    StOddRow: state_d = StOddRow;
                    default:  state_d = StEvenRow;
                endcase
            end
        end else if (ce && end_in) begin
            col_d   = '0;
            row_d   = '0;
            state_d = StIdle;
        end
    end

    // Pulses only arise from accepted samples, so a ce=0 edge clears them naturally.
    always_comb begin
        valid_d = emit;
        end_d   = emit && (row_q == WinLast) && (col_q == WinLast);
        data_d  = emit ? result : data_q;
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < int'(H); i++) begin
                linebuf_q[i] <= '0;
            end
        end else if (lb_we) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign end_out   = end_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Directed and randomized checks of conv_maxpool for an even (m=6) and odd (m=5) map size.
module tb_conv_maxpool;

    logic        clk = 1'b0;
    logic        global_rst_n;
    logic        ce;
    logic [15:0] data_in;
    logic        valid_in;
    logic        end_in;
    logic [15:0] data_out6, data_out5;
    logic        valid_out6, valid_out5;
    logic        end_out6, end_out5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_maxpool #(.N(16), .Q(12), .m(6)) u_dut6 (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ce           (ce),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .end_in       (end_in),
        .data_out     (data_out6),
        .valid_out    (valid_out6),
        .end_out      (end_out6)
    );

    conv_maxpool #(.N(16), .Q(12), .m(5)) u_dut5 (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ce           (ce),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .end_in       (end_in),
        .data_out     (data_out5),
        .valid_out    (valid_out5),
        .end_out      (end_out5)
    );

    // Reference: each map kept as a flat array; a window's max is taken when its bottom-right
    // sample arrives.
    logic signed [15:0] mem [2][0:35];
    int                 kk [2];
    int                 mmv [2] = '{6, 5};
    logic               exp_v [2];
    logic               exp_e [2];
    logic [15:0]        exp_d [2];
    logic [15:0]        obs6 [$];
    logic [15:0]        src [0:35];
    int                 ramp_off [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

    function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 2; i++) begin
            kk[i] = 0; exp_v[i] = 1'b0; exp_e[i] = 1'b0; exp_d[i] = 16'h0000;
        end
    endtask

    task automatic ref_step(input int i, input logic v, input logic [15:0] d, input logic e,
                            input logic c);
        int k, r, col, mm, h;
        logic signed [15:0] p;
        exp_v[i] = 1'b0;
        exp_e[i] = 1'b0;
        mm = mmv[i];
        h  = mm / 2;
        if (c && v) begin
            k = kk[i];
            r = k / mm;
            col = k % mm;
            mem[i][k] = d;
            if (r % 2 == 1 && col % 2 == 1) begin
                p = smax(smax(mem[i][k-mm-1], mem[i][k-mm]), smax(mem[i][k-1], mem[i][k]));
`ifdef MAXPOOL_RELU_EN
                if (p < 0) p = 16'sh0000;
`endif
                exp_v[i] = 1'b1;
                exp_d[i] = p;
                exp_e[i] = (r == 2 * h - 1) && (col == 2 * h - 1);
            end
            kk[i] = (k + 1 == mm * mm || e) ? 0 : k + 1;
        end else if (c && e) begin
            kk[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        chk("valid6", {15'd0, valid_out6}, {15'd0, exp_v[0]});
        chk("end6",   {15'd0, end_out6},   {15'd0, exp_e[0]});
        chk("data6",  data_out6, exp_d[0]);
        chk("valid5", {15'd0, valid_out5}, {15'd0, exp_v[1]});
        chk("end5",   {15'd0, end_out5},   {15'd0, exp_e[1]});
        chk("data5",  data_out5, exp_d[1]);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic e, input logic c);
        valid_in = v; data_in = d; end_in = e; ce = c;
        for (int i = 0; i < 2; i++) ref_step(i, v, d, e, c);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (valid_out6 === 1'b1) obs6.push_back(data_out6);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 16'($urandom), 1'b0, 1'b1);
    endtask

    // mode 0: back-to-back; 1: idle every third cycle; 2: random bubbles and ce drops;
    // 3: 5-cycle ce stall after sample 15.
    task automatic play(input int n, input int end_at, input int mode);
        int cyc = 0;
        obs6.delete();
        for (int j = 0; j < n; j++) begin
            if (mode == 1 && cyc % 3 == 2) begin
                drive(1'b0, 16'($urandom), 1'b0, 1'b1);
                cyc++;
            end
            if (mode == 2) begin
                while ($urandom_range(3) == 0)
                    drive(1'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(1)));
            end
            if (mode == 3 && j == 16) begin
                for (int s = 0; s < 5; s++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
            end
            drive(1'b1, src[j], (j == end_at), 1'b1);
            cyc++;
        end
    endtask

    task automatic check_ramp(input string tag, input int base);
        chk({tag, "_count"}, 16'(obs6.size()), 16'd9);
        for (int j = 0; j < 9 && j < obs6.size(); j++)
            chk(tag, obs6[j], 16'(base + ramp_off[j]));
    endtask

    task automatic fill_ramp(input int base);
        for (int j = 0; j < 36; j++) src[j] = 16'(base + j);
    endtask

    initial begin
        global_rst_n = 1'b0;
        ce = 1'b0; valid_in = 1'b0; end_in = 1'b0; data_in = 16'h0000;
        ref_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        global_rst_n = 1'b1;
        idle(2);

        fill_ramp(0);
        play(36, 35, 0);
        check_ramp("ramp", 0);
        idle(3);

        for (int j = 0; j < 36; j++) src[j] = 16'hF000;
        play(36, 35, 0);
        chk("neg_count", 16'(obs6.size()), 16'd9);
`ifdef MAXPOOL_RELU_EN
        foreach (obs6[j]) chk("neg_relu", obs6[j], 16'h0000);
`else
        foreach (obs6[j]) chk("neg", obs6[j], 16'hF000);
`endif
        idle(2);

        for (int j = 0; j < 36; j++) src[j] = 16'($urandom);
        src[0] = 16'h8000; src[1] = 16'h7FFF; src[6] = 16'h0001; src[7] = 16'hFFFF;
        src[2] = 16'hFFFE; src[3] = 16'hFFFF; src[8] = 16'h8000; src[9] = 16'hF000;
        play(36, 35, 0);
        if (obs6.size() >= 2) begin
            chk("mixed_a", obs6[0], 16'h7FFF);
`ifdef MAXPOOL_RELU_EN
            chk("mixed_b", obs6[1], 16'h0000);
`else
            chk("mixed_b", obs6[1], 16'hFFFF);
`endif
        end else begin
            chk("mixed_count", 16'(obs6.size()), 16'd9);
        end
        idle(2);

        fill_ramp(0);
        play(36, 35, 1);
        check_ramp("bubble", 0);
        idle(2);

        play(36, 35, 3);
        check_ramp("stall", 0);
        idle(2);

        play(21, 20, 0);
        idle(2);
        fill_ramp(100);
        play(36, 35, 0);
        check_ramp("after_early", 100);
        idle(2);

        fill_ramp(0);
        for (int j = 0; j <= 10; j++) drive(1'b1, src[j], 1'b0, 1'b1);
        #2;
        global_rst_n = 1'b0;
        #1;
        ref_reset();
        check_outputs();
        @(negedge clk);
        global_rst_n = 1'b1;
        play(36, 35, 0);
        check_ramp("after_reset", 0);
        idle(2);

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 36; j++) src[j] = 16'($urandom);
            play(36, (t == 4) ? 17 : 35, 2);
            idle(2);
            drive(1'b0, 16'h0000, (t == 2), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
